mips_instr_encoder: RTL and testbench

//  Inverse of the main decoder: accepts symbolic instruction requests (op, rs, rt, rd, shamt, imm)
//  and emits 32-bit MIPS instruction words into instruction memory at a sequential address.

---
 rtl/mips_instr_encoder_pkg.sv | 36 +++
 rtl/mips_instr_encoder_if.sv | 30 +++
 rtl/mips_instr_encoder_pack.sv | 65 ++++++
 rtl/mips_instr_encoder.sv | 104 ++++++++++
 tb/tb_mips_instr_encoder.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_instr_encoder_pkg.sv
// mips_instr_encoder_pkg: MIPS opcode/funct constants, encoder op set and field packing helpers
package mips_instr_encoder_pkg;
  localparam int INSTR_WIDTH = 32;
  typedef enum logic [5:0] {
    OPC_SPECIAL  = 6'h00, OPC_REGIMM = 6'h01, OPC_J    = 6'h02, OPC_JAL  = 6'h03,
    OPC_BEQ      = 6'h04, OPC_BNE    = 6'h05, OPC_BLEZ = 6'h06, OPC_BGTZ = 6'h07,
    OPC_ADDI     = 6'h08, OPC_ADDIU  = 6'h09, OPC_SLTI = 6'h0A, OPC_SLTIU = 6'h0B,
    OPC_ANDI     = 6'h0C, OPC_ORI    = 6'h0D, OPC_XORI = 6'h0E, OPC_LUI  = 6'h0F,
    OPC_SPECIAL2 = 6'h1C, OPC_LB     = 6'h20, OPC_LH   = 6'h21, OPC_LW   = 6'h23,
    OPC_LBU      = 6'h24, OPC_LHU    = 6'h25, OPC_SW   = 6'h2B
  } opcode_t;
  typedef enum logic [5:0] {
    F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04, F_SRLV = 6'h06,
    F_SRAV = 6'h07, F_JR   = 6'h08, F_JALR = 6'h09, F_ADD = 6'h20, F_ADDU = 6'h21,
    F_SUB  = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24, F_OR   = 6'h25, F_XOR  = 6'h26,
    F_NOR  = 6'h27, F_SLT  = 6'h2A, F_SLTU = 6'h2B
  } funct_t;
  typedef enum logic [5:0] {
    OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
    OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV,
    OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
    OP_LW, OP_LB, OP_LH, OP_LBU, OP_LHU, OP_SW,
    OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ, OP_BGEZ,
    OP_J, OP_JAL, OP_JR, OP_JALR, OP_MUL, OP_NOP, OP_LI
  } enc_op_t;
  typedef enum logic [1:0] {IDLE, EMIT, EMIT_HI, EMIT_LO} enc_state_t;
  localparam logic [5:0] R_FUNCT_MUL = 6'h02;
  localparam logic [INSTR_WIDTH-1:0] NOP_WORD = '0;
  localparam logic [4:0] REG_RA = 5'd31;
  function automatic logic [31:0] r_word(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [4:0] sh, logic [5:0] f);
    return {OPC_SPECIAL, rs, rt, rd, sh, f};
  endfunction
  function automatic logic [31:0] i_word(opcode_t o, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {o, rs, rt, imm};
  endfunction
endpackage

// File: rtl/mips_instr_encoder_if.sv
// mips_instr_encoder_if: request bus from the loader and write bus toward instruction memory
interface mips_instr_encoder_if
  import mips_instr_encoder_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
);
  logic                   clear;
  logic                   req_valid;
  logic                   req_ready;
  logic [5:0]             req_op;
  logic [4:0]             req_rs;
  logic [4:0]             req_rt;
  logic [4:0]             req_rd;
  logic [4:0]             req_shamt;
  logic [31:0]            req_imm;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [INSTR_WIDTH-1:0] wr_data;
  logic                   full;
  logic                   err_illegal;
  modport master (
    output clear, req_valid, req_op, req_rs, req_rt, req_rd, req_shamt, req_imm, wr_ready,
    input  req_ready, wr_valid, wr_addr, wr_data, full, err_illegal
  );
  modport slave (
    input  clear, req_valid, req_op, req_rs, req_rt, req_rd, req_shamt, req_imm, wr_ready,
    output req_ready, wr_valid, wr_addr, wr_data, full, err_illegal
  );
endinterface

// File: rtl/mips_instr_encoder_pack.sv
// mips_instr_encoder_pack: combinational op + fields -> 32-bit MIPS word; flags unsupported ops
module mips_instr_encoder_pack
  import mips_instr_encoder_pkg::*;
(
  input  logic [5:0]  i_op,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_shamt,
  input  logic [25:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_legal
);
  logic [15:0] w_imm;
  assign w_imm = i_imm[15:0];
  always_comb begin
    o_word  = NOP_WORD;
    o_legal = 1'b1;
    case (i_op)
      OP_ADD:   o_word = r_word(i_rs, i_rt, i_rd, 5'd0, F_ADD);
      OP_ADDU:  o_word = r_word(i_rs, i_rt, i_rd, 5'd0, F_ADDU);
      OP_SUB:   o_word = r_word(i_rs, i_rt, i_rd, 5'd0, F_SUB);
      OP_SUBU:  o_word = r_word(i_rs, i_rt, i_rd, 5'd0, F_SUBU);
      OP_AND:   o_word = r_word(i_rs, i_rt, i_rd, 5'd0, F_AND);
      OP_OR:    o_word = r_word(i_rs, i_rt, i_rd, 5'd0, F_OR);
      OP_XOR:   o_word = r_word(i_rs, i_rt, i_rd, 5'd0, F_XOR);
      OP_NOR:   o_word = r_word(i_rs, i_rt, i_rd, 5'd0, F_NOR);
      OP_SLT:   o_word = r_word(i_rs, i_rt, i_rd, 5'd0, F_SLT);
      OP_SLTU:  o_word = r_word(i_rs, i_rt, i_rd, 5'd0, F_SLTU);
      OP_SLL:   o_word = r_word(5'd0, i_rt, i_rd, i_shamt, F_SLL);
      OP_SRL:   o_word = r_word(5'd0, i_rt, i_rd, i_shamt, F_SRL);
      OP_SRA:   o_word = r_word(5'd0, i_rt, i_rd, i_shamt, F_SRA);
      OP_SLLV:  o_word = r_word(i_rs, i_rt, i_rd, 5'd0, F_SLLV);
      OP_SRLV:  o_word = r_word(i_rs, i_rt, i_rd, 5'd0, F_SRLV);
      OP_SRAV:  o_word = r_word(i_rs, i_rt, i_rd, 5'd0, F_SRAV);
      OP_ADDI:  o_word = i_word(OPC_ADDI, i_rs, i_rt, w_imm);
      OP_ADDIU: o_word = i_word(OPC_ADDIU, i_rs, i_rt, w_imm);
      OP_SLTI:  o_word = i_word(OPC_SLTI, i_rs, i_rt, w_imm);
      OP_SLTIU: o_word = i_word(OPC_SLTIU, i_rs, i_rt, w_imm);
      OP_ANDI:  o_word = i_word(OPC_ANDI, i_rs, i_rt, w_imm);
      OP_ORI:   o_word = i_word(OPC_ORI, i_rs, i_rt, w_imm);
      OP_XORI:  o_word = i_word(OPC_XORI, i_rs, i_rt, w_imm);
      OP_LUI:   o_word = i_word(OPC_LUI, 5'd0, i_rt, w_imm);
      OP_LW:    o_word = i_word(OPC_LW, i_rs, i_rt, w_imm);
      OP_LB:    o_word = i_word(OPC_LB, i_rs, i_rt, w_imm);
      OP_LH:    o_word = i_word(OPC_LH, i_rs, i_rt, w_imm);
      OP_LBU:   o_word = i_word(OPC_LBU, i_rs, i_rt, w_imm);
      OP_LHU:   o_word = i_word(OPC_LHU, i_rs, i_rt, w_imm);
      OP_SW:    o_word = i_word(OPC_SW, i_rs, i_rt, w_imm);
      OP_BEQ:   o_word = i_word(OPC_BEQ, i_rs, i_rt, w_imm);
      OP_BNE:   o_word = i_word(OPC_BNE, i_rs, i_rt, w_imm);
      OP_BLEZ:  o_word = i_word(OPC_BLEZ, i_rs, 5'd0, w_imm);
      OP_BGTZ:  o_word = i_word(OPC_BGTZ, i_rs, 5'd0, w_imm);
      OP_BLTZ:  o_word = i_word(OPC_REGIMM, i_rs, 5'd0, w_imm);
      OP_BGEZ:  o_word = i_word(OPC_REGIMM, i_rs, 5'd1, w_imm);
      OP_J:     o_word = {OPC_J, i_imm};
      OP_JAL:   o_word = {OPC_JAL, i_imm};
      OP_JR:    o_word = r_word(i_rs, 5'd0, 5'd0, 5'd0, F_JR);
      OP_JALR:  o_word = r_word(i_rs, 5'd0, i_rd == 5'd0 ? REG_RA : i_rd, 5'd0, F_JALR);
      OP_MUL:   o_word = {OPC_SPECIAL2, i_rs, i_rt, i_rd, 5'd0, R_FUNCT_MUL};
      OP_NOP:   o_word = NOP_WORD;
      default:  o_legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: accepts symbolic requests, writes encoded words to sequential imem addresses
// LI expands to LUI(+ORI); the write pointer saturates at the last address and raises full.
module mips_instr_encoder
  import mips_instr_encoder_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
)(
  input logic                  clk,
  input logic                  rst,
  mips_instr_encoder_if.slave  bus
);
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  enc_state_t            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_data;
  logic                  r_valid;
  logic                  r_full;
  logic                  r_err;
  logic [4:0]            r_rt;
  logic [15:0]           r_lo;
  logic                  w_idle;
  logic                  w_accept;
  logic                  w_hs;
  logic                  w_li;
  logic                  w_li_hi;
  logic                  w_li_lo;
  logic [5:0]            w_p_op;
  logic [4:0]            w_p_rs;
  logic [4:0]            w_p_rt;
  logic [25:0]           w_p_imm;
  logic [31:0]           w_word;
  logic                  w_legal;
  assign w_idle   = r_state == IDLE;
  assign w_accept = bus.req_valid & bus.req_ready;
  assign w_hs     = r_valid & bus.wr_ready;
  assign w_li     = bus.req_op == OP_LI;
  assign w_li_hi  = |bus.req_imm[31:16];
  assign w_li_lo  = |bus.req_imm[15:0];
  // Idle: pack the incoming request (LI mapped to its first word); otherwise the pending LI ORI half
  assign w_p_op  = !w_idle ? OP_ORI : w_li ? (w_li_hi ? OP_LUI : OP_ORI) : bus.req_op;
  assign w_p_rs  = !w_idle ? r_rt : w_li ? 5'd0 : bus.req_rs;
  assign w_p_rt  = w_idle ? bus.req_rt : r_rt;
  assign w_p_imm = !w_idle ? {10'd0, r_lo} : (w_li & w_li_hi) ? {10'd0, bus.req_imm[31:16]} : bus.req_imm[25:0];
  mips_instr_encoder_pack u_pack (
    .i_op    (w_p_op),
    .i_rs    (w_p_rs),
    .i_rt    (w_p_rt),
    .i_rd    (bus.req_rd),
    .i_shamt (bus.req_shamt),
    .i_imm   (w_p_imm),
    .o_word  (w_word),
    .o_legal (w_legal)
  );
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_addr  <= BASE;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
      r_data  <= rst ? '0 : r_data;
    end else begin
      if (w_hs) begin
        r_full <= r_full | (r_addr == LAST);
        r_addr <= r_addr == LAST ? r_addr : r_addr + 1'b1;
      end
      case (r_state)
        IDLE: if (w_accept) begin
          if (!w_legal) r_err <= 1'b1;
          else begin
            r_valid <= 1'b1;
            r_data  <= w_word;
            r_rt    <= bus.req_rt;
            r_lo    <= bus.req_imm[15:0];
            r_state <= (w_li & w_li_hi & w_li_lo) ? EMIT_HI : EMIT;
          end
        end
        EMIT_HI: if (w_hs) begin
          if (r_addr == LAST) begin
            r_valid <= 1'b0;
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_data  <= w_word;
            r_state <= EMIT_LO;
          end
        end
        EMIT, EMIT_LO: if (w_hs) begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.req_ready   = w_idle & ~r_full;
  assign bus.wr_valid    = r_valid;
  assign bus.wr_addr     = r_addr;
  assign bus.wr_data     = r_data;
  assign bus.full        = r_full;
  assign bus.err_illegal = r_err;
endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb_mips_instr_encoder: directed + random requests against a mnemonic-level encoding model
module tb_mips_instr_encoder;
  import mips_instr_encoder_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_bad = 0;
  logic sel = 1'b0;
  logic clear = 1'b0, req_valid = 1'b0, wr_ready = 1'b1;
  logic [5:0] op = '0;
  logic [4:0] rs = '0, rt = '0, rd = '0, sh = '0;
  logic [31:0] imm = '0;
  int m_ptr = 0, m_max = 255;
  bit m_full = 1'b0, m_err = 1'b0;
  mips_instr_encoder_if #(.ADDR_WIDTH(8)) bus_a();
  mips_instr_encoder_if #(.ADDR_WIDTH(2)) bus_b();
  mips_instr_encoder #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  mips_instr_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));
  assign bus_a.clear = clear;       assign bus_b.clear = clear;
  assign bus_a.req_valid = req_valid & ~sel;
  assign bus_b.req_valid = req_valid & sel;
  assign bus_a.req_op = op;         assign bus_b.req_op = op;
  assign bus_a.req_rs = rs;         assign bus_b.req_rs = rs;
  assign bus_a.req_rt = rt;         assign bus_b.req_rt = rt;
  assign bus_a.req_rd = rd;         assign bus_b.req_rd = rd;
  assign bus_a.req_shamt = sh;      assign bus_b.req_shamt = sh;
  assign bus_a.req_imm = imm;       assign bus_b.req_imm = imm;
  assign bus_a.wr_ready = wr_ready; assign bus_b.wr_ready = wr_ready;
  logic o_vld, o_rdy, o_full, o_err;
  logic [7:0] o_addr;
  logic [31:0] o_data;
  assign o_vld  = sel ? bus_b.wr_valid : bus_a.wr_valid;
  assign o_rdy  = sel ? bus_b.req_ready : bus_a.req_ready;
  assign o_full = sel ? bus_b.full : bus_a.full;
  assign o_err  = sel ? bus_b.err_illegal : bus_a.err_illegal;
  assign o_addr = sel ? {6'd0, bus_b.wr_addr} : bus_a.wr_addr;
  assign o_data = sel ? bus_b.wr_data : bus_a.wr_data;

  task automatic chk(input string tag, input string what, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, got, exp);
    end
  endtask

  function automatic int unsigned rf(int unsigned s, int unsigned t, int unsigned d, int unsigned a, int unsigned f);
    return s * 2**21 + t * 2**16 + d * 2**11 + a * 64 + f;
  endfunction
  function automatic int unsigned ifm(int unsigned o, int unsigned s, int unsigned t, int unsigned i);
    return o * 2**26 + s * 2**21 + t * 2**16 + i % 65536;
  endfunction

  // Expected word list straight from the MIPS instruction formats
  function automatic void model(input logic [5:0] o, input int unsigned s, input int unsigned t, input int unsigned d,
                                input int unsigned a, input int unsigned i, output int n, output int unsigned w0, output int unsigned w1);
    n = 1; w0 = 0; w1 = 0;
    case (o)
      OP_ADD: w0 = rf(s, t, d, 0, 32);    OP_ADDU: w0 = rf(s, t, d, 0, 33);
      OP_SUB: w0 = rf(s, t, d, 0, 34);    OP_SUBU: w0 = rf(s, t, d, 0, 35);
      OP_AND: w0 = rf(s, t, d, 0, 36);    OP_OR:   w0 = rf(s, t, d, 0, 37);
      OP_XOR: w0 = rf(s, t, d, 0, 38);    OP_NOR:  w0 = rf(s, t, d, 0, 39);
      OP_SLT: w0 = rf(s, t, d, 0, 42);    OP_SLTU: w0 = rf(s, t, d, 0, 43);
      OP_SLL: w0 = rf(0, t, d, a, 0);     OP_SRL:  w0 = rf(0, t, d, a, 2);
      OP_SRA: w0 = rf(0, t, d, a, 3);     OP_SLLV: w0 = rf(s, t, d, 0, 4);
      OP_SRLV: w0 = rf(s, t, d, 0, 6);    OP_SRAV: w0 = rf(s, t, d, 0, 7);
      OP_ADDI: w0 = ifm(8, s, t, i);      OP_ADDIU: w0 = ifm(9, s, t, i);
      OP_SLTI: w0 = ifm(10, s, t, i);     OP_SLTIU: w0 = ifm(11, s, t, i);
      OP_ANDI: w0 = ifm(12, s, t, i);     OP_ORI:   w0 = ifm(13, s, t, i);
      OP_XORI: w0 = ifm(14, s, t, i);     OP_LUI:   w0 = ifm(15, 0, t, i);
      OP_LW: w0 = ifm(35, s, t, i);       OP_LB:  w0 = ifm(32, s, t, i);
      OP_LH: w0 = ifm(33, s, t, i);       OP_LBU: w0 = ifm(36, s, t, i);
      OP_LHU: w0 = ifm(37, s, t, i);      OP_SW:  w0 = ifm(43, s, t, i);
      OP_BEQ: w0 = ifm(4, s, t, i);       OP_BNE:  w0 = ifm(5, s, t, i);
      OP_BLEZ: w0 = ifm(6, s, 0, i);      OP_BGTZ: w0 = ifm(7, s, 0, i);
      OP_BLTZ: w0 = ifm(1, s, 0, i);      OP_BGEZ: w0 = ifm(1, s, 1, i);
      OP_J: w0 = 2 * 2**26 + i % 2**26;   OP_JAL: w0 = 3 * 2**26 + i % 2**26;
      OP_JR: w0 = rf(s, 0, 0, 0, 8);      OP_JALR: w0 = rf(s, 0, d == 0 ? 31 : d, 0, 9);
      OP_MUL: w0 = 28 * 2**26 + rf(s, t, d, 0, 2);
      OP_NOP: w0 = 0;
      OP_LI: begin
        if (i / 65536 == 0) w0 = ifm(13, 0, t, i);
        else begin
          w0 = ifm(15, 0, t, i / 65536);
          if (i % 65536 != 0) begin n = 2; w1 = ifm(13, t, t, i); end
        end
      end
      default: n = 0;
    endcase
  endfunction

  task automatic send(input string tag, input logic [5:0] o, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                      input logic [4:0] a, input logic [31:0] i, input bit rnd, input int stall);
    int n, g;
    int unsigned w0, w1;
    model(o, s, t, d, a, i, n, w0, w1);
    g = 0;
    while (!o_rdy && g < 20) begin @(negedge clk); g++; end
    chk(tag, "req_ready", o_rdy, 1);
    op = o; rs = s; rt = t; rd = d; sh = a; imm = i; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    if (n == 0) m_err = 1'b1;
    if (stall > 0) begin
      wr_ready = 1'b0;
      repeat (stall) begin
        chk(tag, "stall_valid", o_vld, 1);
        chk(tag, "stall_addr", o_addr, m_ptr);
        chk(tag, "stall_data", o_data, w0);
        chk(tag, "stall_req_ready", o_rdy, 0);
        @(negedge clk);
      end
    end
    for (int k = 0; k < n; k++) begin
      if (m_full) begin m_err = 1'b1; break; end
      g = 0;
      wr_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      while (!(o_vld && wr_ready) && g < 30) begin
        @(negedge clk);
        g++;
        wr_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      chk(tag, "wr_valid", o_vld, 1);
      chk(tag, "wr_addr", o_addr, m_ptr);
      chk(tag, "wr_data", o_data, k == 0 ? w0 : w1);
      @(negedge clk);
      if (m_ptr == m_max) m_full = 1'b1; else m_ptr++;
    end
    wr_ready = 1'b1;
    chk(tag, "idle_valid", o_vld, 0);
    chk(tag, "ptr", o_addr, m_ptr);
    chk(tag, "full", o_full, m_full);
    chk(tag, "err", o_err, m_err);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset", "wr_valid", o_vld, 0);
    chk("reset", "wr_addr", o_addr, 0);
    chk("reset", "wr_data", o_data, 0);
    chk("reset", "full", o_full, 0);
    chk("reset", "err", o_err, 0);
    chk("reset", "req_ready", o_rdy, 1);
    send("add", OP_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0, 1'b0, 0);
    send("addi", OP_ADDI, 5'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 0);
    send("sll", OP_SLL, 5'd0, 5'd1, 5'd2, 5'd4, 32'd0, 1'b0, 0);
    send("li_two", OP_LI, 5'd0, 5'd4, 5'd0, 5'd0, 32'h12345678, 1'b0, 0);
    send("li_lo", OP_LI, 5'd0, 5'd4, 5'd0, 5'd0, 32'h00000042, 1'b0, 0);
    send("li_hi", OP_LI, 5'd0, 5'd9, 5'd0, 5'd0, 32'hABCD0000, 1'b0, 0);
    send("jalr0", OP_JALR, 5'd7, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 0);
    send("mul", OP_MUL, 5'd3, 5'd4, 5'd5, 5'd0, 32'd0, 1'b0, 0);
    send("bgez", OP_BGEZ, 5'd6, 5'd9, 5'd0, 5'd0, 32'hFFFF_FFFC, 1'b0, 0);
    send("jal", OP_JAL, 5'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 0);
    send("nop", OP_NOP, 5'd1, 5'd2, 5'd3, 5'd4, 32'h1234, 1'b0, 0);
    send("li_stall", OP_LI, 5'd0, 5'd7, 5'd0, 5'd0, 32'hDEADBEEF, 1'b0, 3);
    send("illegal", 6'h3F, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0, 1'b0, 0);
    for (int r = 0; r < 40; r++) begin
      logic [5:0] o;
      logic [31:0] i;
      logic [4:0] a;
      o = 6'($urandom_range(0, OP_LI));
      if ($urandom_range(0, 9) == 0) o = 6'($urandom_range(OP_LI + 1, 63));
      i = $urandom;
      case ($urandom_range(0, 3))
        0: i[31:16] = '0;
        1: i[15:0] = '0;
        default: ;
      endcase
      a = (o == OP_SLL || o == OP_SRL || o == OP_SRA) ? 5'($urandom) : 5'd0;
      send("rnd", o, 5'($urandom), 5'($urandom), 5'($urandom), a, i, 1'b1, 0);
    end
    // clear in the same cycle as a write handshake drops the word
    op = OP_ADD; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; wr_ready = 1'b1; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_ptr = 0; m_full = 1'b0; m_err = 1'b0;
    chk("clear_hs", "wr_valid", o_vld, 0);
    chk("clear_hs", "wr_addr", o_addr, 0);
    chk("clear_hs", "err", o_err, 0);
    chk("clear_hs", "req_ready", o_rdy, 1);
    send("post_clear", OP_SUB, 5'd8, 5'd9, 5'd10, 5'd0, 32'd0, 1'b0, 0);
    // reset while the LUI half of an LI is still waiting
    op = OP_LI; rt = 5'd3; imm = 32'h00010001; wr_ready = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_li", "pending", o_vld, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; wr_ready = 1'b1;
    @(negedge clk);
    m_ptr = 0;
    chk("rst_li", "wr_valid", o_vld, 0);
    chk("rst_li", "wr_addr", o_addr, 0);
    chk("rst_li", "wr_data", o_data, 0);
    chk("rst_li", "req_ready", o_rdy, 1);
    send("post_rst", OP_OR, 5'd1, 5'd1, 5'd1, 5'd0, 32'd0, 1'b0, 0);
    // four-word memory: fill, clear, then LI overflowing at the last address
    sel = 1'b1; m_ptr = 0; m_max = 3; m_full = 1'b0; m_err = 1'b0;
    for (int k = 0; k < 4; k++) send("fill", OP_ADD, 5'(k), 5'd2, 5'd3, 5'd0, 32'd0, 1'b0, 0);
    chk("full", "req_ready", o_rdy, 0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_ptr = 0; m_full = 1'b0; m_err = 1'b0;
    chk("clr", "wr_addr", o_addr, 0);
    chk("clr", "full", o_full, 0);
    chk("clr", "req_ready", o_rdy, 1);
    for (int k = 0; k < 3; k++) send("pre_li", OP_XOR, 5'd4, 5'(k), 5'd6, 5'd0, 32'd0, 1'b0, 0);
    send("li_ovf", OP_LI, 5'd0, 5'd4, 5'd0, 5'd0, 32'h12345678, 1'b0, 0);
    chk("li_ovf", "req_ready", o_rdy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
